// File: rtl/legv8_store_buffer.sv
// rtl/legv8_store_buffer.sv - LEGv8 data-memory store buffer with load forwarding
//
// Buffers stores from the MEM stage in a circular FIFO and drains them to a
// backing RAM through a valid/ready handshake. Loads are answered in the
// request cycle from the youngest buffered store to the same doubleword,
// falling back to the RAM's asynchronous read data.
//
// Optional build macro: LEGV8_STBUF_COALESCE_EN
//   When defined, a store that hits a buffered non-head entry overwrites that
//   entry's data instead of allocating a new one.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          synchronous active-low reset
//   MemRead_DM   load request
//   MemWrite_DM  store request
//   address_DM   load/store byte address (doubleword compared on [63:3])
//   WD_DM        store data
//   RD_DM        load data, combinational
//   mem_raddr    RAM read address (= address_DM)
//   mem_rdata    RAM read data
//   mem_wvalid   drain request, head entry present
//   mem_waddr    drain address (head entry)
//   mem_wdata    drain data (head entry)
//   mem_wready   RAM accepts drain this cycle
//   count        number of buffered stores
//   full         count == DEPTH
//   empty        count == 0
//   overflow     sticky: a store was dropped while full
module legv8_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     MemRead_DM,
    input  logic                     MemWrite_DM,
    input  logic [63:0]              address_DM,
    input  logic [63:0]              WD_DM,
    output logic [63:0]              RD_DM,
    output logic [63:0]              mem_raddr,
    input  logic [63:0]              mem_rdata,
    output logic                     mem_wvalid,
    output logic [63:0]              mem_waddr,
    output logic [63:0]              mem_wdata,
    input  logic                     mem_wready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ONE   = (PW+1)'(1);
    localparam logic [PW:0]   CNT_DEPTH = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    logic [63:0]   ent_addr [DEPTH];
    logic [63:0]   ent_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic          pop;
    logic          push;
    logic          drop;
    logic          coal_hit;
    logic [63:0]   fwd_data;
    logic [PW-1:0] fwd_idx;

    assign empty      = (count == '0);
    assign full       = (count == CNT_DEPTH);
    assign mem_wvalid = !empty;
    assign mem_waddr  = ent_addr[head];
    assign mem_wdata  = ent_data[head];
    assign mem_raddr  = address_DM;

    // Load forwarding: walk from oldest to youngest so the last hit wins.
    // Uses pre-store state, so a simultaneous load+store sees old contents.
    // MemRead_DM does not gate the result; RD_DM is don't-care without a load.
    always_comb begin
        fwd_data = mem_rdata;
        fwd_idx  = head;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PW'(i);
            if (i < int'(count) && ent_addr[fwd_idx][63:3] == address_DM[63:3]) begin
                fwd_data = ent_data[fwd_idx];
            end
        end
    end

    assign RD_DM = fwd_data;

`ifdef LEGV8_STBUF_COALESCE_EN
    logic [PW-1:0] coal_idx;
    logic [PW-1:0] coal_scan;

    // Youngest matching entry excluding the head: the head may be on the bus
    // to the RAM right now, so its data must stay stable until accepted.
    always_comb begin
        coal_hit  = 1'b0;
        coal_idx  = head;
        coal_scan = head;
        for (int i = 1; i < DEPTH; i++) begin
            coal_scan = head + PW'(i);
            if (i < int'(count) && ent_addr[coal_scan][63:3] == address_DM[63:3]) begin
                coal_hit = 1'b1;
                coal_idx = coal_scan;
            end
        end
    end
`else
    assign coal_hit = 1'b0;
`endif

    // A pop frees a slot in the same edge, so a store into a full buffer is
    // still accepted when the head drains that cycle.
    assign pop  = rst && mem_wvalid && mem_wready;
    assign push = rst && MemWrite_DM && !coal_hit && (!full || pop);
    assign drop = rst && MemWrite_DM && !coal_hit && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                head <= head + PTR_ONE;
            end
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Entry storage needs no reset; validity is tracked by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= address_DM;
            ent_data[tail] <= WD_DM;
        end
`ifdef LEGV8_STBUF_COALESCE_EN
        if (rst && MemWrite_DM && coal_hit) begin
            ent_data[coal_idx] <= WD_DM;
        end
`endif
    end

endmodule

// File: tb/tb_legv8_store_buffer.sv
// tb/tb_legv8_store_buffer.sv - self-checking bench for legv8_store_buffer
module tb_legv8_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_DM;
    logic        MemWrite_DM;
    logic [63:0] address_DM;
    logic [63:0] WD_DM;
    logic [63:0] RD_DM;
    logic [63:0] mem_raddr;
    logic [63:0] mem_rdata;
    logic        mem_wvalid;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic        mem_wready;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;

    always #5 clk = ~clk;

    legv8_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .MemRead_DM(MemRead_DM), .MemWrite_DM(MemWrite_DM),
        .address_DM(address_DM), .WD_DM(WD_DM), .RD_DM(RD_DM),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wready(mem_wready),
        .count(count), .full(full), .empty(empty), .overflow(overflow)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
    } ent_t;

    ent_t        mq[$];
    bit          m_ovf;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] drained[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_rd(input logic [63:0] a, input logic [63:0] rdata);
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a[63:3] == a[63:3]) return mq[i].d;
        end
        return rdata;
    endfunction

    // One clock cycle: drive, check outputs mid-cycle against the model,
    // advance the model, then step past the rising edge.
    task automatic cyc(input bit r, input bit rd, input bit wr, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] rdata, input bit wrdy);
        bit pop;
        int ci;
        rst         = r;
        MemRead_DM  = rd;
        MemWrite_DM = wr;
        address_DM  = a;
        WD_DM       = wd;
        mem_rdata   = rdata;
        mem_wready  = wrdy;
        #2;
        chk("count", 64'(count), 64'(mq.size()));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("wvalid", 64'(mem_wvalid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("waddr", mem_waddr, mq[0].a);
            chk("wdata", mem_wdata, mq[0].d);
        end
        chk("rd", RD_DM, model_rd(a, rdata));
        chk("raddr", mem_raddr, a);
        if (r && wrdy && mem_wvalid) drained.push_back(mem_waddr);

        if (!r) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            pop = (mq.size() != 0) && wrdy;
            ci  = -1;
`ifdef LEGV8_STBUF_COALESCE_EN
            if (wr) begin
                for (int i = mq.size() - 1; i >= 1; i--) begin
                    if (mq[i].a[63:3] == a[63:3]) begin
                        ci = i;
                        break;
                    end
                end
            end
`endif
            if (ci >= 0) mq[ci].d = wd;
            if (pop) void'(mq.pop_front());
            if (wr && ci < 0) begin
                if (mq.size() < DEPTH) mq.push_back('{a: a, d: wd});
                else m_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0);
    endtask

    initial begin
        logic [63:0] ra;
        rst = 1'b0; MemRead_DM = 1'b0; MemWrite_DM = 1'b0;
        address_DM = '0; WD_DM = '0; mem_rdata = '0; mem_wready = 1'b0;
        @(posedge clk);
        #1;
        mq.delete();
        m_ovf = 1'b0;

        // Reset state
        do_reset();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_wvalid", 64'(mem_wvalid), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // Single store held at the head
        cyc(1, 0, 1, 64'h10, 64'hAA, 64'h0, 0);
        chk("st_count", 64'(count), 64'd1);
        chk("st_wvalid", 64'(mem_wvalid), 64'd1);
        chk("st_waddr", mem_waddr, 64'h10);
        chk("st_wdata", mem_wdata, 64'hAA);

        // Youngest duplicate forwards; filler keeps 0x20 entries off the head
        do_reset();
        cyc(1, 0, 1, 64'h08, 64'h77, 64'h0, 0);
        cyc(1, 0, 1, 64'h20, 64'h1, 64'h0, 0);
        cyc(1, 0, 1, 64'h24, 64'h2, 64'h0, 0);
        cyc(1, 1, 0, 64'h20, 64'h0, 64'h0, 0);
        chk("dup_rd", RD_DM, 64'h2);
`ifdef LEGV8_STBUF_COALESCE_EN
        chk("dup_count", 64'(count), 64'd2);
`else
        chk("dup_count", 64'(count), 64'd3);
`endif
        // Load+store same cycle returns pre-store data
        cyc(1, 1, 1, 64'h20, 64'h3, 64'h0, 0);
        cyc(1, 1, 0, 64'h20, 64'h0, 64'h0, 0);
        chk("ldst_after", RD_DM, 64'h3);

        // Full: drop without pop, accept with pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, 64'h40 + 64'(i * 8), 64'(i), 64'h0, 0);
        cyc(1, 0, 1, 64'h80, 64'hF, 64'h0, 0);
        chk("drop_ovf", 64'(overflow), 64'd1);
        chk("drop_count", 64'(count), 64'd4);
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, 64'h40 + 64'(i * 8), 64'(i), 64'h0, 0);
        cyc(1, 0, 1, 64'h80, 64'hF, 64'h0, 1);
        chk("fullpop_ovf", 64'(overflow), 64'd0);
        chk("fullpop_count", 64'(count), 64'd4);
        chk("fullpop_head", mem_waddr, 64'h48);

        // Empty buffer load goes straight to RAM data
        do_reset();
        cyc(1, 1, 0, 64'h30, 64'h0, 64'h55, 0);
        chk("miss_rd", RD_DM, 64'h55);

        // Reset mid-handshake discards everything, including a store
        cyc(1, 0, 1, 64'h100, 64'h1, 64'h0, 0);
        cyc(1, 0, 1, 64'h108, 64'h2, 64'h0, 0);
        cyc(1, 0, 1, 64'h110, 64'h3, 64'h0, 0);
        cyc(0, 0, 1, 64'h118, 64'h4, 64'h0, 1);
        chk("rstmid_count", 64'(count), 64'd0);
        chk("rstmid_wvalid", 64'(mem_wvalid), 64'd0);
        chk("rstmid_ovf", 64'(overflow), 64'd0);

        // Streaming push/pop wraps the pointers; drain order equals store order
        do_reset();
        drained.delete();
        for (int i = 0; i < 6; i++) cyc(1, 0, 1, 64'h200 + 64'(i * 8), 64'(i), 64'h0, 1);
        cyc(1, 0, 0, 64'h0, 64'h0, 64'h0, 1);
        cyc(1, 0, 0, 64'h0, 64'h0, 64'h0, 1);
        chk("wrap_ndrain", 64'(drained.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < drained.size()) chk("wrap_order", drained[i], 64'h200 + 64'(i * 8));
        end

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            ra = (64'($urandom_range(0, 7)) << 3) | 64'($urandom_range(0, 7));
            cyc(($urandom_range(0, 49) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0),
                ra, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
